arbitrary_pattern_gen: RTL and testbench
========================================

Name: arbitrary_pattern_gen

Overview:
- Single-clock arbitrary pattern generator and logic capture block for NUM_SIG digital lines.
- Software streams a pattern of up to NUM_SAMP words into an output memory through a write strobe, then pulses run.
- The block plays the pattern on output_signals at a divided "wave" rate and simultaneously captures input_signals into an input memory.
- Software drains the captured words through a read strobe. The block sits behind an AXI register slave.

Parameters:
- NUM_SIG, 8: width of the output pattern, input capture and data channels.
- NUM_SAMP, 128: depth of each memory, in samples.
- WAVE_DIV, 100: axi_clk cycles per wave step. Must be at least 2.

Ports:
- axi_clk  input  1  sole clock; all state changes on the rising edge.
- axi_resetn  input  1  asynchronous, active-low reset.
- run  input  1  start request, level-sampled each cycle.
- write_channel  input  NUM_SIG  pattern word to append.
- write_channel_wrStrobe  input  1  append write_channel this cycle.
- read_channel  output  NUM_SIG  captured word, registered.
- read_channel_rdStrobe  input  1  pop the next captured word this cycle.
- output_signals  output  NUM_SIG  pattern drive, registered.
- input_signals  input  NUM_SIG  lines to capture; assumed synchronous to axi_clk.

Behaviour:
- Reset values:
  - output_signals=0, read_channel=0.
  - wr_cnt=0, rd_ptr=0, cap_cnt=0, step=0, divider=0.
  - state=IDLE; a "fresh" flag (marks that the next write starts a new pattern) is set to 0.
  - Memory contents are not reset.
- States are IDLE, RUN and DONE. DONE behaves as IDLE, except that the first wrStrobe in DONE clears wr_cnt before writing, so a new pattern is loaded.
- Write path:
  - In IDLE or DONE, wrStrobe stores write_channel into out_mem[wr_cnt] and increments wr_cnt.
  - When wr_cnt==NUM_SAMP, further writes are dropped.
  - Writes during RUN are ignored.
- Run start:
  - run=1 in IDLE or DONE with wr_cnt>0 moves the block to RUN.
  - On entry: step=0, divider=0, rd_ptr=0, cap_cnt=0, and output_signals<=out_mem[0] on the next edge.
  - run with wr_cnt==0 is ignored. run while in RUN is ignored.
  - If run and wrStrobe are asserted in the same cycle, the write is performed first and run is honoured on the next cycle if still high.
- RUN:
  - The divider counts 0..WAVE_DIV-1. At a terminal count (a "tick"), in_mem[step]<=input_signals and cap_cnt<=step+1.
  - If step+1<wr_cnt: output_signals<=out_mem[step+1] and step++.
  - Otherwise: output_signals<=0 and state<=DONE.
  - Each pattern word is therefore held for exactly WAVE_DIV cycles. The capture for word k happens on the edge where word k+1 appears.
- Read path:
  - rdStrobe with rd_ptr<cap_cnt gives read_channel<=in_mem[rd_ptr] and rd_ptr++, with 1-cycle latency.
  - rdStrobe with rd_ptr>=cap_cnt gives read_channel<=0 and the pointer holds.
  - rdStrobe during RUN is allowed and returns only samples already captured.
  - When rdStrobe is 0, read_channel holds its last value.
- Reset mid-run: immediate return to IDLE, output_signals=0, pattern length lost.
- Counters are $clog2(NUM_SAMP)+1 bits wide so that full (==NUM_SAMP) is representable. No wrap-around.

Decomposition:
- Package apg_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - the localparam ADDR_W=$clog2(NUM_SAMP);
  - the localparam CNT_W=ADDR_W+1.
- One sub-module, apg_sample_ram: a simple dual-port RAM with synchronous write and registered read, parameterised by width and depth.
  - It is instantiated twice, for out_mem and in_mem.
  - The top contains the FSM, the divider and the pointers.

Test Plan:
- Pattern and capture:
  - Stimulus: write 1,3,7,15,31,63 on consecutive cycles, pulse run for 1 cycle, then drive input_signals 42,85,42,85,0,127, changing just after each tick.
  - Required: output_signals steps 1,3,7,15,31,63, each held WAVE_DIV cycles, then returns to 0. A 6-cycle rdStrobe burst yields read_channel 42,85,42,85,0,127.
- Over-read: on the same bench, a 9-cycle rdStrobe burst yields 42,85,42,85,0,127,0,0,0.
- Empty run: pulse run after reset with no writes -> state stays IDLE and output_signals stays 0.
- Ignored writes: writes during RUN leave the pattern unchanged. Writing 5,6 after DONE, then running, plays only 5,6.
- Full memory: 130 writes with values 0..129 -> plays 128 steps (0..127); the last two writes are dropped.
- Reset mid-run: deassert axi_resetn during step 3 -> output_signals=0 asynchronously, and a subsequent run is ignored until new writes arrive.

Source files
------------

// File: rtl/apg_pkg.sv
// Shared types and default widths for the arbitrary pattern generator.
package apg_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } apg_state_e;

  // Widths for the default 128-sample memories. Counters carry one extra bit
  // so that a completely full memory (count == depth) is representable.
  localparam int ADDR_W = $clog2(128);
  localparam int CNT_W  = ADDR_W + 1;

endpackage

// File: rtl/apg_sample_ram.sv
// Simple dual-port sample memory: synchronous write, registered read with enable.
module apg_sample_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 128,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             axi_clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Store a sample when the write port is enabled.
  always_ff @(posedge axi_clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Registered read; the output holds while rd_en is low.
  always_ff @(posedge axi_clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/arbitrary_pattern_gen.sv
// Arbitrary pattern generator with simultaneous logic capture.
// Software appends pattern words, pulses run, and the pattern is played on
// output_signals one word per WAVE_DIV cycles while input_signals is sampled
// at the end of every word. Captured words are drained through read_channel.
module arbitrary_pattern_gen
  import apg_pkg::*;
#(
  parameter int NUM_SIG  = 8,
  parameter int NUM_SAMP = 1 << ADDR_W,
  parameter int WAVE_DIV = 100
) (
  input  logic               axi_clk,
  input  logic               axi_resetn,
  input  logic               run,
  input  logic [NUM_SIG-1:0] write_channel,
  input  logic               write_channel_wrStrobe,
  output logic [NUM_SIG-1:0] read_channel,
  input  logic               read_channel_rdStrobe,
  output logic [NUM_SIG-1:0] output_signals,
  input  logic [NUM_SIG-1:0] input_signals
);

  // Package widths describe the default depth; other depths derive their own.
  localparam int CW = (NUM_SAMP == (1 << ADDR_W)) ? CNT_W : $clog2(NUM_SAMP) + 1;
  localparam int AW = CW - 1;
  localparam int DW = (WAVE_DIV > 2) ? $clog2(WAVE_DIV) : 1;
  localparam logic [CW-1:0] FULL     = CW'(NUM_SAMP);
  localparam logic [DW-1:0] DIV_LAST = DW'(WAVE_DIV - 1);

  apg_state_e         state_q, state_d;
  logic [CW-1:0]      wr_cnt, rd_ptr, cap_cnt, step, step_nxt;
  logic [DW-1:0]      divider;
  logic               fresh;
  logic               rd_zero;
  logic [NUM_SIG-1:0] word0;
  logic [NUM_SIG-1:0] out_rdata, in_rdata;
  logic [AW-1:0]      wr_addr;
  logic               idle_like, wr_fire, run_go, tick, last, rd_hit;

  assign idle_like = (state_q != RUN);
  // A fresh pattern restarts at address 0 and is never blocked by a full memory.
  assign wr_fire   = idle_like && write_channel_wrStrobe && (fresh || (wr_cnt < FULL));
  assign wr_addr   = fresh ? '0 : wr_cnt[AW-1:0];
  // A coincident write wins; run is seen again on the following cycle.
  assign run_go    = idle_like && run && !write_channel_wrStrobe && (wr_cnt != '0);
  assign tick      = (state_q == RUN) && (divider == DIV_LAST);
  assign step_nxt  = step + 1'b1;
  assign last      = !(step_nxt < wr_cnt);
  assign rd_hit    = read_channel_rdStrobe && (rd_ptr < cap_cnt);

  // Captured words read as zero until the first successful pop and after an over-read.
  assign read_channel = rd_zero ? '0 : in_rdata;

  // Pattern memory; the read port continuously prefetches the word after the current one.
  apg_sample_ram #(.WIDTH(NUM_SIG), .DEPTH(NUM_SAMP)) u_out_mem (
    .axi_clk (axi_clk),
    .wr_en   (wr_fire),
    .wr_addr (wr_addr),
    .wr_data (write_channel),
    .rd_en   (1'b1),
    .rd_addr (step_nxt[AW-1:0]),
    .rd_data (out_rdata)
  );

  // Capture memory; written at each tick, read on a successful pop.
  apg_sample_ram #(.WIDTH(NUM_SIG), .DEPTH(NUM_SAMP)) u_in_mem (
    .axi_clk (axi_clk),
    .wr_en   (tick),
    .wr_addr (step[AW-1:0]),
    .wr_data (input_signals),
    .rd_en   (rd_hit),
    .rd_addr (rd_ptr[AW-1:0]),
    .rd_data (in_rdata)
  );

  // State register.
  always_ff @(posedge axi_clk or negedge axi_resetn) begin
    if (!axi_resetn) state_q <= IDLE;
    else             state_q <= state_d;
  end

  // Next-state logic: start on a valid run, finish after the last word's tick.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (run_go) state_d = RUN;
      RUN:        if (tick && last) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  // Write counter and fresh-pattern flag.
  always_ff @(posedge axi_clk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      wr_cnt <= '0;
      fresh  <= 1'b0;
    end else begin
      if (wr_fire) begin
        wr_cnt <= fresh ? CW'(1) : wr_cnt + 1'b1;
        fresh  <= 1'b0;
      end else if (tick && last) begin
        fresh  <= 1'b1;
      end
    end
  end

  // Shadow of word 0 so playback can start on the entry edge, even right after writing it.
  always_ff @(posedge axi_clk) begin
    if (wr_fire && (wr_addr == '0)) word0 <= write_channel;
  end

  // Wave-rate divider and step pointer.
  always_ff @(posedge axi_clk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      divider <= '0;
      step    <= '0;
    end else if (run_go) begin
      divider <= '0;
      step    <= '0;
    end else if (state_q == RUN) begin
      if (tick) begin
        divider <= '0;
        if (!last) step <= step_nxt;
      end else begin
        divider <= divider + 1'b1;
      end
    end
  end

  // Pattern drive: word 0 on entry, next word at each tick, zero after the last.
  always_ff @(posedge axi_clk or negedge axi_resetn) begin
    if (!axi_resetn)  output_signals <= '0;
    else if (run_go)  output_signals <= word0;
    else if (tick)    output_signals <= last ? '0 : out_rdata;
  end

  // Capture count and read pointer.
  always_ff @(posedge axi_clk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      cap_cnt <= '0;
      rd_ptr  <= '0;
    end else if (run_go) begin
      cap_cnt <= '0;
      rd_ptr  <= '0;
    end else begin
      if (tick)   cap_cnt <= step_nxt;
      if (rd_hit) rd_ptr  <= rd_ptr + 1'b1;
    end
  end

  // Read-channel zero flag: updated on every pop attempt, held otherwise.
  always_ff @(posedge axi_clk or negedge axi_resetn) begin
    if (!axi_resetn)                rd_zero <= 1'b1;
    else if (read_channel_rdStrobe) rd_zero <= !rd_hit;
  end

endmodule

// File: tb/tb_arbitrary_pattern_gen.sv
// Directed plus randomized bench for arbitrary_pattern_gen with a queue-based model.
module tb_arbitrary_pattern_gen;

  localparam int NS = 8;
  localparam int NSAMP = 128;
  localparam int WD = 6;

  logic          axi_clk = 1'b0;
  logic          axi_resetn;
  logic          run;
  logic [NS-1:0] write_channel;
  logic          write_channel_wrStrobe;
  logic [NS-1:0] read_channel;
  logic          read_channel_rdStrobe;
  logic [NS-1:0] output_signals;
  logic [NS-1:0] input_signals;

  arbitrary_pattern_gen #(.NUM_SIG(NS), .NUM_SAMP(NSAMP), .WAVE_DIV(WD)) dut (
    .axi_clk                (axi_clk),
    .axi_resetn             (axi_resetn),
    .run                    (run),
    .write_channel          (write_channel),
    .write_channel_wrStrobe (write_channel_wrStrobe),
    .read_channel           (read_channel),
    .read_channel_rdStrobe  (read_channel_rdStrobe),
    .output_signals         (output_signals),
    .input_signals          (input_signals)
  );

  always #5 axi_clk = ~axi_clk;

  // Reference model: the loaded pattern, captured samples and read position.
  logic [NS-1:0] pat[$];
  logic [NS-1:0] cap[$];
  logic [NS-1:0] in_q[$];
  logic [NS-1:0] wq[$];
  int  rd_idx;
  bit  fresh;
  int  n_cmp = 0;
  int  n_err = 0;

  task automatic step();
    @(posedge axi_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    pat.delete();
    cap.delete();
    rd_idx = 0;
    fresh = 1'b0;
  endtask

  // Append words from wq; optionally hold run high during the last write.
  task automatic write_words(input bit run_on_last);
    for (int i = 0; i < wq.size(); i++) begin
      write_channel = wq[i];
      write_channel_wrStrobe = 1'b1;
      if (run_on_last && i == wq.size() - 1) run = 1'b1;
      if (fresh) begin
        pat.delete();
        fresh = 1'b0;
      end
      if (pat.size() < NSAMP) pat.push_back(wq[i]);
      step();
    end
    write_channel_wrStrobe = 1'b0;
  endtask

  // Run the loaded pattern, checking every cycle; in_q supplies the capture values.
  task automatic play(input bit junk);
    run = 1'b1;
    step();
    run = 1'b0;
    for (int k = 0; k < pat.size(); k++) begin
      for (int c = 0; c < WD; c++) begin
        if (c == 0) input_signals = in_q[k];
        chk("out_word", output_signals, pat[k]);
        if (junk && c == 1) begin
          write_channel = NS'($urandom);
          write_channel_wrStrobe = 1'b1;
        end else begin
          write_channel_wrStrobe = 1'b0;
        end
        step();
      end
    end
    write_channel_wrStrobe = 1'b0;
    input_signals = NS'($urandom);
    chk("out_after", output_signals, 0);
    cap.delete();
    for (int k = 0; k < pat.size(); k++) cap.push_back(in_q[k]);
    rd_idx = 0;
    fresh = 1'b1;
  endtask

  task automatic rd_burst(input int n);
    logic [NS-1:0] exp;
    exp = '0;
    for (int i = 0; i < n; i++) begin
      read_channel_rdStrobe = 1'b1;
      step();
      if (rd_idx < cap.size()) begin
        exp = cap[rd_idx];
        rd_idx++;
      end else begin
        exp = '0;
      end
      chk("rd_data", read_channel, exp);
    end
    read_channel_rdStrobe = 1'b0;
    step();
    if (n > 0) chk("rd_hold", read_channel, exp);
  endtask

  task automatic run_ignored(input string tag);
    run = 1'b1;
    step();
    run = 1'b0;
    for (int c = 0; c < 2 * WD; c++) begin
      chk(tag, output_signals, 0);
      step();
    end
  endtask

  initial begin
    axi_resetn = 1'b0;
    run = 1'b0;
    write_channel = '0;
    write_channel_wrStrobe = 1'b0;
    read_channel_rdStrobe = 1'b0;
    input_signals = '0;
    model_reset();
    step();
    step();
    chk("rst_out", output_signals, 0);
    chk("rst_rd", read_channel, 0);
    axi_resetn = 1'b1;
    step();

    // Empty run after reset does nothing.
    run_ignored("empty_run");

    // Main pattern and capture.
    wq = '{8'd1, 8'd3, 8'd7, 8'd15, 8'd31, 8'd63};
    write_words(1'b0);
    in_q = '{8'd42, 8'd85, 8'd42, 8'd85, 8'd0, 8'd127};
    play(1'b0);
    rd_burst(6);

    // Replay from DONE, then over-read.
    play(1'b0);
    rd_burst(9);

    // New pattern after DONE with run overlapping the last write; writes during run ignored.
    wq = '{8'd5, 8'd6};
    write_words(1'b1);
    in_q = '{8'd17, 8'd200};
    play(1'b1);
    rd_burst(3);

    // Full memory: 130 writes, the last two dropped.
    wq.delete();
    for (int i = 0; i < 130; i++) wq.push_back(NS'(i));
    write_words(1'b0);
    chk("full_len", pat.size(), 128);
    in_q.delete();
    for (int i = 0; i < NSAMP; i++) in_q.push_back(NS'($urandom));
    play(1'b0);
    rd_burst(10);

    // Randomized patterns.
    for (int it = 0; it < 4; it++) begin
      int len;
      len = $urandom_range(1, 12);
      wq.delete();
      in_q.delete();
      for (int i = 0; i < len; i++) begin
        wq.push_back(NS'($urandom));
        in_q.push_back(NS'($urandom));
      end
      write_words(1'($urandom_range(0, 1)));
      play(1'($urandom_range(0, 1)));
      rd_burst($urandom_range(0, len + 3));
    end

    // Reset during step 3.
    wq = '{8'd9, 8'd10, 8'd11, 8'd12, 8'd13};
    write_words(1'b0);
    run = 1'b1;
    step();
    run = 1'b0;
    for (int k = 0; k < 3; k++) begin
      for (int c = 0; c < WD; c++) begin
        chk("pre_rst_out", output_signals, pat[k]);
        step();
      end
    end
    chk("step3_out", output_signals, pat[3]);
    step();
    axi_resetn = 1'b0;
    #1;
    chk("async_rst_out", output_signals, 0);
    chk("async_rst_rd", read_channel, 0);
    step();
    axi_resetn = 1'b1;
    model_reset();
    step();
    run_ignored("run_after_rst");
    rd_burst(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
